rob_completion_tracker: RTL and testbench

- Receiving end of the ROB update interface driven by the complete stage.
- Tracks in-order entry allocation from dispatch and absorbs up to N completion updates per cycle (complete, mispredict, branch outcome).
- Retires up to N contiguous completed entries per cycle from the head.
- Raises a flush with redirect target when a retiring entry mispredicted.

---
 rtl/rob_completion_tracker.sv | 144 ++++++++++++++
 tb/tb_rob_completion_tracker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_completion_tracker.sv
// Reorder-buffer completion tracker: in-order allocation, out-of-order completion
// updates, and in-order retirement of up to N entries per cycle with mispredict flush.
module rob_completion_tracker #(
  parameter int N      = 3,
  parameter int ROB_SZ = 32,
  parameter int IDX_W  = $clog2(ROB_SZ),
  parameter int XLEN   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [$clog2(N+1)-1:0] alloc_cnt,
  output logic [N*IDX_W-1:0]     alloc_idx,
  output logic [IDX_W:0]         free_slots,
  input  logic [N-1:0]           upd_valid,
  input  logic [N*IDX_W-1:0]     upd_idx,
  input  logic [N-1:0]           upd_mispredict,
  input  logic [N-1:0]           upd_branch_taken,
  input  logic [N*XLEN-1:0]      upd_branch_target,
  output logic [N-1:0]           retire_valid,
  output logic [N*IDX_W-1:0]     retire_idx,
  output logic [N-1:0]           retire_taken,
  output logic                   flush,
  output logic [XLEN-1:0]        flush_target
);
  localparam int CNT_W = $clog2(N+1);

  logic [IDX_W-1:0]  head_reg, tail_reg;
  logic [IDX_W:0]    count_reg;
  logic [ROB_SZ-1:0] valid_reg, complete_reg, mispredict_reg, taken_reg;
  logic [XLEN-1:0]   target_mem [ROB_SZ];

  logic [CNT_W-1:0]  retire_cnt, accepted;
  logic [IDX_W-1:0]  upd_lane_idx [N];
  logic [N-1:0]      upd_ok;

  assign free_slots = (IDX_W+1)'(ROB_SZ) - count_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign alloc_idx[gi*IDX_W +: IDX_W]  = tail_reg + IDX_W'(gi);
    assign retire_idx[gi*IDX_W +: IDX_W] = head_reg + IDX_W'(gi);
    assign upd_lane_idx[gi] = upd_idx[gi*IDX_W +: IDX_W];
    // Entries retiring this cycle sit at offsets below retire_cnt from head; their updates are dropped.
    assign upd_ok[gi] = upd_valid[gi] && valid_reg[upd_lane_idx[gi]] &&
                        ((upd_lane_idx[gi] - head_reg) >= IDX_W'(retire_cnt));
  end

  // Retire scan: contiguous completed entries, stopping after the first mispredict.
  always_comb begin
    logic             stop;
    logic [IDX_W-1:0] ridx;
    stop         = 1'b0;
    ridx         = head_reg;
    retire_valid = '0;
    retire_taken = '0;
    retire_cnt   = '0;
    flush        = 1'b0;
    flush_target = '0;
    for (int i = 0; i < N; i++) begin
      ridx = head_reg + IDX_W'(i);
      if (!stop && valid_reg[ridx] && complete_reg[ridx]) begin
        retire_valid[i] = 1'b1;
        retire_taken[i] = taken_reg[ridx];
        retire_cnt      = retire_cnt + 1'b1;
        if (mispredict_reg[ridx]) begin
          flush        = 1'b1;
          flush_target = target_mem[ridx];
          stop         = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    if (flush)
      accepted = '0;
    else if ((IDX_W+1)'(alloc_cnt) > free_slots)
      accepted = CNT_W'(free_slots);
    else
      accepted = alloc_cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      valid_reg      <= '0;
      complete_reg   <= '0;
      mispredict_reg <= '0;
      taken_reg      <= '0;
    end else if (flush) begin
      valid_reg    <= '0;
      complete_reg <= '0;
      head_reg     <= head_reg + IDX_W'(retire_cnt);
      tail_reg     <= head_reg + IDX_W'(retire_cnt);
      count_reg    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (retire_valid[i]) begin
          valid_reg[head_reg + IDX_W'(i)]    <= 1'b0;
          complete_reg[head_reg + IDX_W'(i)] <= 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (CNT_W'(i) < accepted) begin
          valid_reg[tail_reg + IDX_W'(i)]      <= 1'b1;
          complete_reg[tail_reg + IDX_W'(i)]   <= 1'b0;
          mispredict_reg[tail_reg + IDX_W'(i)] <= 1'b0;
          taken_reg[tail_reg + IDX_W'(i)]      <= 1'b0;
        end
      end
      // Ascending lane order so the highest lane wins on a shared index.
      for (int i = 0; i < N; i++) begin
        if (upd_ok[i]) begin
          complete_reg[upd_lane_idx[i]]   <= 1'b1;
          mispredict_reg[upd_lane_idx[i]] <= upd_mispredict[i];
          taken_reg[upd_lane_idx[i]]      <= upd_branch_taken[i];
        end
      end
      head_reg  <= head_reg + IDX_W'(retire_cnt);
      tail_reg  <= tail_reg + IDX_W'(accepted);
      count_reg <= count_reg + (IDX_W+1)'(accepted) - (IDX_W+1)'(retire_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      for (int i = 0; i < N; i++)
        if (CNT_W'(i) < accepted)
          target_mem[tail_reg + IDX_W'(i)] <= '0;
      for (int i = 0; i < N; i++)
        if (upd_ok[i])
          target_mem[upd_lane_idx[i]] <= upd_branch_target[i*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)
      assert ((IDX_W+1)'(alloc_cnt) <= free_slots)
        else $warning("rob_completion_tracker: alloc_cnt %0d exceeds free_slots %0d", alloc_cnt, free_slots);
  end
endmodule

// File: tb/tb_rob_completion_tracker.sv
// Directed and randomized checks of rob_completion_tracker against a queue-based ROB model.
module tb_rob_completion_tracker;
  localparam int N = 3, ROB_SZ = 32, IDX_W = 5, XLEN = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   alloc_cnt = '0;
  logic [14:0]  alloc_idx;
  logic [5:0]   free_slots;
  logic [2:0]   upd_valid = '0;
  logic [14:0]  upd_idx = '0;
  logic [2:0]   upd_mispredict = '0;
  logic [2:0]   upd_branch_taken = '0;
  logic [95:0]  upd_branch_target = '0;
  logic [2:0]   retire_valid;
  logic [14:0]  retire_idx;
  logic [2:0]   retire_taken;
  logic         flush;
  logic [31:0]  flush_target;

  rob_completion_tracker #(.N(N), .ROB_SZ(ROB_SZ), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .alloc_cnt(alloc_cnt), .alloc_idx(alloc_idx),
    .free_slots(free_slots), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_mispredict(upd_mispredict), .upd_branch_taken(upd_branch_taken),
    .upd_branch_target(upd_branch_target), .retire_valid(retire_valid),
    .retire_idx(retire_idx), .retire_taken(retire_taken), .flush(flush),
    .flush_target(flush_target)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          idx;
    bit          comp;
    bit          misp;
    bit          taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];      // live entries, oldest first
  int   m_head = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
  endtask

  task automatic set_upd(input int lane, input int idx, input bit misp, input bit tk,
                         input logic [31:0] tgt);
    upd_valid[lane]                 = 1'b1;
    upd_idx[lane*IDX_W +: IDX_W]    = 5'(idx);
    upd_mispredict[lane]            = misp;
    upd_branch_taken[lane]          = tk;
    upd_branch_target[lane*32 +: 32] = tgt;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    alloc_cnt = '0;
    upd_valid = '0;
    @(posedge clock);
    @(negedge clock);
    reset  = 1'b0;
    q.delete();
    m_head = 0;
  endtask

  // Check outputs against the model, clock once, then advance the model.
  task automatic tick();
    int          ret, free, acc, tail;
    bit          mflush;
    logic [31:0] mtgt;
    logic [2:0]  erv, ert;
    logic [14:0] eai, eri;
    ent_t        e;
    #1;
    ret = 0; mflush = 0; mtgt = '0; erv = '0; ert = '0;
    for (int i = 0; i < N; i++) begin
      if (i >= q.size()) break;
      if (!q[i].comp) break;
      erv[i] = 1'b1;
      ert[i] = q[i].taken;
      ret++;
      if (q[i].misp) begin
        mflush = 1'b1;
        mtgt   = q[i].tgt;
        break;
      end
    end
    free = ROB_SZ - q.size();
    tail = (m_head + q.size()) % ROB_SZ;
    acc  = mflush ? 0 : ((int'(alloc_cnt) > free) ? free : int'(alloc_cnt));
    for (int i = 0; i < N; i++) begin
      eai[i*IDX_W +: IDX_W] = 5'((tail + i) % ROB_SZ);
      eri[i*IDX_W +: IDX_W] = 5'((m_head + i) % ROB_SZ);
    end
    chk("free_slots", free_slots, free);
    chk("alloc_idx", alloc_idx, eai);
    chk("retire_valid", retire_valid, erv);
    chk("retire_idx", retire_idx, eri);
    chk("retire_taken", retire_taken, ert);
    chk("flush", flush, mflush);
    chk("flush_target", flush_target, mtgt);
    if (erv != 0)
      $display("retire lanes=%b head=%0d flush=%0b target=%0h", retire_valid, m_head, flush, flush_target);
    @(posedge clock);
    for (int l = 0; l < N; l++) begin
      if (upd_valid[l]) begin
        for (int j = ret; j < q.size(); j++) begin
          if (q[j].idx == int'(upd_idx[l*IDX_W +: IDX_W])) begin
            q[j].comp  = 1'b1;
            q[j].misp  = upd_mispredict[l];
            q[j].taken = upd_branch_taken[l];
            q[j].tgt   = upd_branch_target[l*32 +: 32];
          end
        end
      end
    end
    m_head = (m_head + ret) % ROB_SZ;
    if (mflush) begin
      q.delete();
    end else begin
      repeat (ret) void'(q.pop_front());
      for (int k = 0; k < acc; k++) begin
        e.idx = (tail + k) % ROB_SZ; e.comp = 0; e.misp = 0; e.taken = 0; e.tgt = '0;
        q.push_back(e);
      end
    end
    @(negedge clock);
    alloc_cnt = '0;
    upd_valid = '0;
  endtask

  initial begin
    int a;
    // Reset state
    do_reset();
    #1;
    chk("rst_free", free_slots, 32);
    chk("rst_alloc_idx", alloc_idx, {5'd2, 5'd1, 5'd0});
    chk("rst_retire_valid", retire_valid, 3'b000);
    chk("rst_flush", flush, 1'b0);
    tick();

    // Out-of-order completion holds retirement until the head completes
    alloc_cnt = 2'd3; tick();
    set_upd(0, 1, 0, 0, 32'h0); tick();
    set_upd(0, 0, 0, 1, 32'h0); tick();
    #1 chk("ooo_retire_valid", retire_valid, 3'b011);
    tick();
    #1 chk("ooo_free", free_slots, 31);
    set_upd(0, 2, 0, 0, 32'h0); tick();
    tick();

    // Mispredict on lane 1 flushes with its target
    do_reset();
    alloc_cnt = 2'd3; tick();
    set_upd(0, 0, 0, 0, 32'h0);
    set_upd(1, 1, 1, 1, 32'h0000_1040);
    set_upd(2, 2, 0, 0, 32'h0);
    tick();
    #1;
    chk("misp_retire_valid", retire_valid, 3'b011);
    chk("misp_flush", flush, 1'b1);
    chk("misp_target", flush_target, 32'h1040);
    tick();
    #1;
    chk("misp_free_after", free_slots, 32);
    chk("misp_alloc_idx_after", alloc_idx, {5'd4, 5'd3, 5'd2});
    tick();

    // Fill to full: final request of 3 accepts only 2
    do_reset();
    repeat (11) begin alloc_cnt = 2'd3; tick(); end
    #1 chk("full_free", free_slots, 0);
    alloc_cnt = 2'd3; tick();
    set_upd(0, 0, 0, 0, 32'h0); set_upd(1, 1, 0, 0, 32'h0); set_upd(2, 2, 0, 1, 32'h0);
    tick();
    tick();
    #1 chk("full_free_after_retire", free_slots, 3);

    // Tail at 31 wraps in alloc_idx
    do_reset();
    repeat (10) begin alloc_cnt = 2'd3; tick(); end
    alloc_cnt = 2'd1; tick();
    set_upd(0, 0, 0, 0, 32'h0); set_upd(1, 1, 0, 0, 32'h0); set_upd(2, 2, 0, 0, 32'h0);
    tick();
    tick();
    #1;
    chk("wrap_alloc_idx", alloc_idx, {5'd1, 5'd0, 5'd31});
    chk("wrap_free", free_slots, 4);
    tick();

    // Same-index updates: highest lane wins; update to unallocated index ignored
    do_reset();
    alloc_cnt = 2'd3; tick();
    alloc_cnt = 2'd3; tick();
    set_upd(0, 0, 0, 0, 32'h0); set_upd(1, 1, 0, 0, 32'h0); set_upd(2, 2, 0, 0, 32'h0);
    tick();
    set_upd(0, 3, 0, 0, 32'h0); set_upd(1, 4, 0, 0, 32'h0);
    tick();
    set_upd(0, 5, 1, 0, 32'h100); set_upd(1, 20, 1, 1, 32'h777); set_upd(2, 5, 1, 1, 32'h200);
    tick();
    #1;
    chk("dup_flush", flush, 1'b1);
    chk("dup_target", flush_target, 32'h200);
    tick();
    tick();

    // Asynchronous reset while a flush is pending with 10 live entries
    do_reset();
    alloc_cnt = 2'd3; tick();
    alloc_cnt = 2'd3; tick();
    alloc_cnt = 2'd3; tick();
    alloc_cnt = 2'd1; tick();
    set_upd(0, 0, 1, 1, 32'hdead_0000); tick();
    #1 chk("pre_async_flush", flush, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_retire_valid", retire_valid, 3'b000);
    chk("async_retire_taken", retire_taken, 3'b000);
    chk("async_flush", flush, 1'b0);
    chk("async_flush_target", flush_target, 32'h0);
    chk("async_free", free_slots, 32);
    chk("async_alloc_idx", alloc_idx, {5'd2, 5'd1, 5'd0});
    chk("async_retire_idx", retire_idx, {5'd2, 5'd1, 5'd0});
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    m_head = 0;
    tick();

    // Randomized traffic against the model
    repeat (3000) begin
      a = int'($urandom_range(0, 3));
      if (a > ROB_SZ - q.size()) a = ROB_SZ - q.size();
      alloc_cnt = 2'(a);
      for (int l = 0; l < N; l++)
        if ($urandom_range(0, 1) == 1)
          set_upd(l, (m_head + int'($urandom_range(0, q.size() + 2))) % ROB_SZ,
                  $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
